// File: rtl/rr_mux16_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux16_sched
//  Description : Round-robin scheduler for a shared 16:1 mux path. Grants one
//                requester at a time, releases on done, on a dropped request
//                or after MAX_HOLD cycles, and inserts one idle turnaround
//                cycle between consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux16_sched #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);

  // Hold counter wide enough for 0..MAX_HOLD-1, never narrower than one bit.
  localparam int c_HOLD_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [15:0]         c_ONE_HOT0  = 16'h0001;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state_q,   state_d;
  logic [3:0]            ptr_q,     ptr_d;
  logic [3:0]            sel_q,     sel_d;
  logic [15:0]           gnt_q,     gnt_d;
  logic                  busy_q,    busy_d;
  logic                  timeout_q, timeout_d;
  logic [c_HOLD_W-1:0]   hold_q,    hold_d;

  logic                  w_pick_found;
  logic [3:0]            w_pick_idx;
  logic [3:0]            w_cand;
  logic                  w_hold_limit;
  logic                  w_normal_rel;

  // Round-robin search: first set request starting at ptr, wrapping mod 16.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = 4'd0;
    w_cand       = 4'd0;
    for (int i = 0; i < 16; i++) begin
      w_cand = ptr_q + 4'(i);
      if (!w_pick_found && req[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  assign w_hold_limit = (hold_q == c_HOLD_LAST);
  // A release caused by done or by the grantee dropping its request is
  // "normal"; only a release forced purely by the hold limit pulses timeout.
  assign w_normal_rel = done | ~req[sel_q];

  // Next-state and registered-output computation for the IDLE/GRANT FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d  = 16'h0000;
        busy_d = 1'b0;
        if (w_pick_found) begin
          state_d = ST_GRANT;
          sel_d   = w_pick_idx;
          gnt_d   = c_ONE_HOT0 << w_pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (w_normal_rel || w_hold_limit) begin
          state_d   = ST_IDLE;
          gnt_d     = 16'h0000;
          busy_d    = 1'b0;
          ptr_d     = sel_q + 4'd1;
          hold_d    = '0;
          timeout_d = w_hold_limit & ~w_normal_rel;
        end else begin
          hold_d = hold_q + c_HOLD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 16'h0000;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 4'd0;
      sel_q     <= 4'd0;
      gnt_q     <= 16'h0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire
